// File: rtl/boe_result_collector.sv
// rtl/boe_result_collector.sv - collects one BOE result frame (max, sum, values) into a report; BOE_RESULT_CHECK_EN builds stream checks
module boe_result_collector #(
   parameter int DW   = 8,
   parameter int RW   = 11,
   parameter int MAXN = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [2:0]    frame_num,
   input  logic          res_valid,
   input  logic [RW-1:0] res_data,
   output logic          busy,
   output logic          rpt_valid,
   input  logic          rpt_ready,
   output logic [DW-1:0] rpt_max,
   output logic [RW-1:0] rpt_sum,
   output logic [DW-1:0] rpt_min,
   output logic [2:0]    rpt_num,
   output logic [2:0]    rpt_err
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CAP_MAX = 3'd1,
      S_CAP_SUM = 3'd2,
      S_CAP_VAL = 3'd3,
      S_REPORT  = 3'd4
   } state_t;

   localparam logic [2:0] MAXN_L = 3'(MAXN);

   state_t        state_q, state_d;
   logic [DW-1:0] max_q, max_d;
   logic [RW-1:0] sum_q, sum_d;
   logic [DW-1:0] min_q, min_d;
   logic [2:0]    num_q, num_d;
   logic [2:0]    idx_q, idx_d;
   logic          rpt_valid_q, rpt_valid_d;

   logic [DW-1:0] val;
   logic          last_val;
   logic [2:0]    num_clamped;

   assign val         = res_data[DW-1:0];
   assign last_val    = (idx_q == (num_q - 3'd1));
   assign num_clamped = (frame_num > MAXN_L) ? MAXN_L : frame_num;

`ifdef BOE_RESULT_CHECK_EN
   logic [RW-1:0] acc_q, acc_d;
   logic [DW-1:0] prev_q, prev_d;
   logic [2:0]    err_q, err_d;
   logic [RW-1:0] acc_nx;

   // running sum including the word on the bus, wraps mod 2^RW
   assign acc_nx = acc_q + RW'(val);
`endif

   // next-state and capture logic for the frame walk
   always_comb begin
      state_d     = state_q;
      max_d       = max_q;
      sum_d       = sum_q;
      min_d       = min_q;
      num_d       = num_q;
      idx_d       = idx_q;
      rpt_valid_d = rpt_valid_q;
`ifdef BOE_RESULT_CHECK_EN
      acc_d       = acc_q;
      prev_d      = prev_q;
      err_d       = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && (frame_num != 3'd0)) begin
               num_d   = num_clamped;
               state_d = S_CAP_MAX;
`ifdef BOE_RESULT_CHECK_EN
               err_d   = 3'b000;
`endif
            end
         end
         S_CAP_MAX: begin
            if (res_valid) begin
               max_d   = val;
               state_d = S_CAP_SUM;
            end
         end
         S_CAP_SUM: begin
            if (res_valid) begin
               sum_d   = res_data;
               idx_d   = 3'd0;
               state_d = S_CAP_VAL;
`ifdef BOE_RESULT_CHECK_EN
               acc_d   = '0;
`endif
            end
         end
         S_CAP_VAL: begin
            if (res_valid) begin
               idx_d = idx_q + 3'd1;
               min_d = val;
`ifdef BOE_RESULT_CHECK_EN
               acc_d  = acc_nx;
               prev_d = val;
               // first value must repeat the max word
               if ((idx_q == 3'd0) && (val != max_q)) begin
                  err_d[0] = 1'b1;
               end
               // descending order and no bits above the item width
               if ((idx_q != 3'd0) && (val > prev_q)) begin
                  err_d[2] = 1'b1;
               end
               if (res_data[RW-1:DW] != '0) begin
                  err_d[2] = 1'b1;
               end
               if (last_val && (acc_nx != sum_q)) begin
                  err_d[1] = 1'b1;
               end
`endif
               if (last_val) begin
                  state_d     = S_REPORT;
                  rpt_valid_d = 1'b1;
               end
            end
         end
         S_REPORT: begin
            // extra result words and start are ignored until the report is taken
            if (rpt_ready) begin
               state_d     = S_IDLE;
               rpt_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            rpt_valid_d = 1'b0;
         end
      endcase
   end

   // state and capture registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         max_q       <= '0;
         sum_q       <= '0;
         min_q       <= '0;
         num_q       <= '0;
         idx_q       <= '0;
         rpt_valid_q <= 1'b0;
`ifdef BOE_RESULT_CHECK_EN
         acc_q       <= '0;
         prev_q      <= '0;
         err_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         max_q       <= max_d;
         sum_q       <= sum_d;
         min_q       <= min_d;
         num_q       <= num_d;
         idx_q       <= idx_d;
         rpt_valid_q <= rpt_valid_d;
`ifdef BOE_RESULT_CHECK_EN
         acc_q       <= acc_d;
         prev_q      <= prev_d;
         err_q       <= err_d;
`endif
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign rpt_valid = rpt_valid_q;
   assign rpt_max   = max_q;
   assign rpt_sum   = sum_q;
   assign rpt_min   = min_q;
   assign rpt_num   = num_q;
`ifdef BOE_RESULT_CHECK_EN
   assign rpt_err   = err_q;
`else
   assign rpt_err   = 3'b000;
`endif

endmodule

// File: tb/tb_boe_result_collector.sv
// tb/tb_boe_result_collector.sv - directed bench for boe_result_collector
module tb_boe_result_collector;

`ifdef BOE_RESULT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  frame_num = 3'd0;
   logic        res_valid = 1'b0;
   logic [10:0] res_data = 11'd0;
   logic        busy;
   logic        rpt_valid;
   logic        rpt_ready = 1'b0;
   logic [7:0]  rpt_max;
   logic [10:0] rpt_sum;
   logic [7:0]  rpt_min;
   logic [2:0]  rpt_num;
   logic [2:0]  rpt_err;

   int checks = 0;
   int failures = 0;

   boe_result_collector #(.DW(8), .RW(11), .MAXN(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .frame_num (frame_num),
      .res_valid (res_valid),
      .res_data  (res_data),
      .busy      (busy),
      .rpt_valid (rpt_valid),
      .rpt_ready (rpt_ready),
      .rpt_max   (rpt_max),
      .rpt_sum   (rpt_sum),
      .rpt_min   (rpt_min),
      .rpt_num   (rpt_num),
      .rpt_err   (rpt_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]       fnum;
      int               nw;
      logic [7:0][10:0] w;
      logic [7:0]       emax;
      logic [10:0]      esum;
      logic [7:0]       emin;
      logic [2:0]       enm;
      logic [2:0]       eerr;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [7:0][10:0] wl(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7);
      logic [7:0][10:0] r;
      r[0] = 11'(a0); r[1] = 11'(a1); r[2] = 11'(a2); r[3] = 11'(a3);
      r[4] = 11'(a4); r[5] = 11'(a5); r[6] = 11'(a6); r[7] = 11'(a7);
      return r;
   endfunction

   function automatic logic [2:0] ex(input logic [2:0] e);
      return CHK ? e : 3'b000;
   endfunction

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h expected=%0h", nm, id, act, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are read 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [10:0] w);
      res_valid = 1'b1;
      res_data  = w;
      step();
      res_valid = 1'b0;
      res_data  = 11'd0;
   endtask

   task automatic open_frame(input logic [2:0] n);
      start     = 1'b1;
      frame_num = n;
      step();
      start     = 1'b0;
   endtask

   task automatic check_report(input int id, input logic [7:0] emax, input logic [10:0] esum,
                               input logic [7:0] emin, input logic [2:0] enm, input logic [2:0] eerr);
      chk("rpt_valid", id, 32'(rpt_valid), 32'd1);
      chk("rpt_max", id, 32'(rpt_max), 32'(emax));
      chk("rpt_sum", id, 32'(rpt_sum), 32'(esum));
      chk("rpt_min", id, 32'(rpt_min), 32'(emin));
      chk("rpt_num", id, 32'(rpt_num), 32'(enm));
      chk("rpt_err", id, 32'(rpt_err), 32'(eerr));
   endtask

   task automatic accept(input int id);
      rpt_ready = 1'b1;
      step();
      rpt_ready = 1'b0;
      chk("valid_after_hs", id, 32'(rpt_valid), 32'd0);
      chk("busy_after_hs", id, 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{3'd3, 5, wl(9, 16, 9, 5, 2, 0, 0, 0), 8'd9, 11'd16, 8'd2, 3'd3, ex(3'b000)};
      vecs[1] = '{3'd3, 5, wl(9, 17, 9, 5, 2, 0, 0, 0), 8'd9, 11'd17, 8'd2, 3'd3, ex(3'b010)};
      vecs[2] = '{3'd3, 5, wl(9, 16, 5, 9, 2, 0, 0, 0), 8'd9, 11'd16, 8'd2, 3'd3, ex(3'b101)};
      vecs[3] = '{3'd7, 8, wl(6, 21, 6, 5, 4, 3, 2, 1), 8'd6, 11'd21, 8'd1, 3'd6, ex(3'b000)};
      vecs[4] = '{3'd2, 4, wl(10, 15, 10, 'h105, 0, 0, 0, 0), 8'd10, 11'd15, 8'd5, 3'd2, ex(3'b100)};

      // reset state
      rst_n = 1'b0;
      step();
      step();
      chk("rst_busy", 0, 32'(busy), 32'd0);
      chk("rst_valid", 0, 32'(rpt_valid), 32'd0);
      chk("rst_max", 0, 32'(rpt_max), 32'd0);
      chk("rst_sum", 0, 32'(rpt_sum), 32'd0);
      chk("rst_min", 0, 32'(rpt_min), 32'd0);
      chk("rst_num", 0, 32'(rpt_num), 32'd0);
      chk("rst_err", 0, 32'(rpt_err), 32'd0);
      rst_n = 1'b1;
      step();

      // frame_num=0 start ignored, stray res_valid in IDLE ignored
      open_frame(3'd0);
      chk("zero_n_busy", 0, 32'(busy), 32'd0);
      send_word(11'd77);
      chk("idle_word_max", 0, 32'(rpt_max), 32'd0);

      // back-to-back table frames
      for (int i = 0; i < 5; i++) begin
         open_frame(vecs[i].fnum);
         chk("busy_open", i, 32'(busy), 32'd1);
         for (int k = 0; k < vecs[i].nw; k++) begin
            if (k == vecs[i].nw - 1) chk("valid_early", i, 32'(rpt_valid), 32'd0);
            send_word(vecs[i].w[k]);
         end
         check_report(i, vecs[i].emax, vecs[i].esum, vecs[i].emin, vecs[i].enm, vecs[i].eerr);
         accept(i);
      end

      // N=1 with gaps and backpressure; extra words and start in REPORT are dropped
      open_frame(3'd1);
      step(); step();
      send_word(11'd200);
      step(); step();
      send_word(11'd200);
      step(); step();
      chk("gap_valid_early", 10, 32'(rpt_valid), 32'd0);
      chk("gap_busy", 10, 32'(busy), 32'd1);
      send_word(11'd200);
      for (int c = 0; c < 5; c++) begin
         check_report(10 + c, 8'd200, 11'd200, 8'd200, 3'd1, ex(3'b000));
         res_valid = 1'b1;
         res_data  = 11'd3;
         start     = 1'b1;
         frame_num = 3'd4;
         step();
      end
      res_valid = 1'b0;
      check_report(15, 8'd200, 11'd200, 8'd200, 3'd1, ex(3'b000));
      // start asserted in the handshake cycle must not open a frame
      frame_num = 3'd2;
      accept(16);
      start = 1'b0;
      step();
      chk("hs_start_ignored", 16, 32'(busy), 32'd0);

      // reset mid-frame after the sum word
      open_frame(3'd3);
      send_word(11'd9);
      send_word(11'd16);
      chk("mid_busy", 20, 32'(busy), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_busy", 20, 32'(busy), 32'd0);
      chk("mid_rst_valid", 20, 32'(rpt_valid), 32'd0);
      chk("mid_rst_max", 20, 32'(rpt_max), 32'd0);
      chk("mid_rst_sum", 20, 32'(rpt_sum), 32'd0);
      chk("mid_rst_num", 20, 32'(rpt_num), 32'd0);
      open_frame(3'd2);
      send_word(11'd4);
      send_word(11'd7);
      send_word(11'd4);
      send_word(11'd3);
      check_report(21, 8'd4, 11'd7, 8'd3, 3'd2, ex(3'b000));
      accept(21);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
